// File: rtl/uart_rx_param_if.sv
// Receiver-to-consumer bundle: the received word, its error flags, the
// valid/ready handshake, the overrun pulse and the busy indication.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        output parity_err,
        output frame_err,
        output overrun,
        output busy
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        input  parity_err,
        input  frame_err,
        input  overrun,
        input  busy
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable width/parity/stop bits, start-bit
// glitch rejection, per-word error flags and valid/ready output with overrun.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | line idle, waiting for a falling edge on rx_s
// S_START   | half a bit period into the start bit; re-check for glitch
// S_DATA    | sampling DATA_BITS payload bits, LSB first
// S_PARITY  | sampling the parity bit
// S_STOP    | sampling STOP_BITS stop bits
// S_DELIVER | one cycle: hand the word to the consumer or flag overrun
// S_RECOVER | framing error seen; wait for the line to return high
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic            CLOCK_50,
    input  logic            rst_n,
    input  logic            rx,
    uart_rx_param_if.master rx_if
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DELIVER,
        S_RECOVER
    } state_t;

    state_t               state_q, state_d;
    logic                 rx_meta_q, rx_s_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_pend_q, perr_pend_d;
    logic                 ferr_pend_q, ferr_pend_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;

    logic tick_full;
    logic tick_half;
    logic par_xor;

    assign tick_full = (cnt_q == CNT_FULL);
    assign tick_half = (cnt_q == CNT_HALF);
    assign par_xor   = ^{shift_q, rx_s_q};

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            perr_pend_q <= 1'b0;
            ferr_pend_q <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            perr_pend_q <= perr_pend_d;
            ferr_pend_q <= ferr_pend_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            ovr_q       <= ovr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        perr_pend_d = perr_pend_q;
        ferr_pend_d = ferr_pend_q;
        data_d      = data_q;
        valid_d     = valid_q;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        ovr_d       = 1'b0;

        if (valid_q && rx_if.rx_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d     = S_START;
                    perr_pend_d = 1'b0;
                    ferr_pend_d = 1'b0;
                end
            end
            S_START: begin
                if (tick_half) begin
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                if (tick_full) begin
                    shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    if (idx_q == LAST_DATA) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (tick_full) begin
                    // odd mode: total ones must be odd; even mode: even
                    perr_pend_d = (PARITY == 1) ? ~par_xor : par_xor;
                    state_d     = S_STOP;
                end
            end
            S_STOP: begin
                if (tick_full) begin
                    if (!rx_s_q) begin
                        ferr_pend_d = 1'b1;
                    end
                    if (idx_q == LAST_STOP) begin
                        state_d = S_DELIVER;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_DELIVER: begin
                if (!valid_q || rx_if.rx_ready) begin
                    data_d  = shift_q;
                    perr_d  = perr_pend_q;
                    ferr_d  = ferr_pend_q;
                    valid_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
                state_d = ferr_pend_q ? S_RECOVER : S_IDLE;
            end
            S_RECOVER: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // one shared bit-period counter, restarted on every state change
        if ((state_d != state_q) || tick_full) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign rx_if.rx_data    = data_q;
    assign rx_if.rx_valid   = valid_q;
    assign rx_if.parity_err = perr_q;
    assign rx_if.frame_err  = ferr_q;
    assign rx_if.overrun    = ovr_q;
    assign rx_if.busy       = (state_q != S_IDLE);
endmodule
